// File: rtl/reg_file_pkg.sv
// Shared defaults and select-width derivation for the register file, hazard unit and pipeline top.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_REGS_DEF = 8;

  // ceil(log2(n)), never below 1 so a select port always exists
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, clr_all wipes; produces decode stall.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned SEL_W    = sel_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEL_W-1:0]    rd_a_sel,
  input  logic [SEL_W-1:0]    rd_b_sel,
  input  logic                issue_vld,
  input  logic [SEL_W-1:0]    issue_dst,
  input  logic                issue_use_a,
  input  logic                issue_use_b,
  input  logic                wb_vld,
  input  logic [SEL_W-1:0]    wb_sel,
  input  logic                clr_all,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] busy_eff;

  // The register being written back this cycle is bypassed, so it must not stall.
  always_comb begin
    wb_mask         = '0;
    wb_mask[wb_sel] = wb_vld;
    busy_eff        = busy_q & ~wb_mask;
    stall = issue_vld && ((issue_use_a && busy_eff[rd_a_sel]) ||
                          (issue_use_b && busy_eff[rd_b_sel]) ||
                          busy_eff[issue_dst]);
  end

  // Set is applied after clear so a new producer supersedes a completing one.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (issue_vld && !stall) busy_d[issue_dst] = 1'b1;
    if (clr_all) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-through read bypass and busy scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned SEL_W     = sel_w(NUM_REGS),
  parameter bit          RESET_IDX = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEL_W-1:0]    rd_a_sel,
  input  logic [SEL_W-1:0]    rd_b_sel,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic [DATA_W-1:0]   rd_b_data,
  input  logic                issue_vld,
  input  logic [SEL_W-1:0]    issue_dst,
  input  logic                issue_use_a,
  input  logic                issue_use_b,
  output logic                stall,
  input  logic                wb_vld,
  input  logic [SEL_W-1:0]    wb_sel,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                clr_all,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (clr_all) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
    end else if (wb_vld) begin
      regs_d[wb_sel] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RESET_IDX ? DATA_W'(i) : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass holds even during clr_all: decode sees the value on the write-back bus.
  always_comb begin
    rd_a_data = (wb_vld && wb_sel == rd_a_sel) ? wb_data : regs_q[rd_a_sel];
    rd_b_data = (wb_vld && wb_sel == rd_b_sel) ? wb_data : regs_q[rd_b_sel];
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_a_sel    (rd_a_sel),
    .rd_b_sel    (rd_b_sel),
    .issue_vld   (issue_vld),
    .issue_dst   (issue_dst),
    .issue_use_a (issue_use_a),
    .issue_use_b (issue_use_b),
    .wb_vld      (wb_vld),
    .wb_sel      (wb_sel),
    .clr_all     (clr_all),
    .stall       (stall),
    .busy_vec    (busy_vec)
  );

endmodule
